// File: rtl/serial_cla_adder_pkg.sv
// Shared types and constants for the serial 2-bit-slice CLA adder.
package serial_cla_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_cla_adder_cla2.sv
// 2-bit carry-lookahead adder slice; the only adder in the serial datapath.
module cla_adder_2bits (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [1:0] g;
  logic [1:0] p;
  logic       c1;

  assign g    = a & b;
  assign p    = a ^ b;
  // Both carries come straight from generate/propagate, no ripple between bits.
  assign c1   = g[0] | (p[0] & cin);
  assign cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign s    = p ^ {c1, cin};

endmodule

// File: rtl/serial_cla_adder.sv
// Serial adder: captures operands, then adds one 2-bit slice per cycle, LSB first.
module serial_cla_adder
  import serial_cla_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovr
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovr_q, ovr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         a_sl, b_sl, sum_sl;
  logic               c_sl;
  logic               last_sl;
  int                 cnt_idx;

  assign cnt_idx = int'(cnt_q);
  assign a_sl    = a_q[2*cnt_idx +: 2];
  assign b_sl    = b_q[2*cnt_idx +: 2];
  assign last_sl = (cnt_q == CNT_W'(SLICES - 1));

  cla_adder_2bits u_cla (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .s    (sum_sl),
    .cout (c_sl)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          s_d     = '0;
          cout_d  = 1'b0;
          ovr_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[2*cnt_idx +: 2] = sum_sl;
        carry_d             = c_sl;
        if (last_sl) begin
          // Final slice holds the sign bit, so overflow is resolved here.
          cnt_d   = '0;
          cout_d  = c_sl;
          ovr_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_sl[1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Table-driven bench with an expected-result queue for serial_cla_adder (WIDTH=8).
module tb_serial_cla_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovr;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
  logic       ovr;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  serial_cla_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    exp_t    r;
    logic [8:0] sum;
    sum    = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
    r.s    = sum[7:0];
    r.cout = sum[8];
    r.ovr  = (ta[7] == tb_[7]) && (sum[7] != ta[7]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, scramble inputs during RUN, check latency and result.
  task automatic do_txn(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input exp_t e, input logic ordy_early);
    int   lat;
    exp_t got;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    sb.push_back(e);
    tick();
    in_valid  = 1'b0;
    out_ready = ordy_early;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      chk({name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    got = sb.pop_front();
    chk({name, "_s"}, 32'(s), 32'(got.s));
    chk({name, "_cout"}, 32'(cout), 32'(got.cout));
    chk({name, "_ovr"}, 32'(ovr), 32'(got.ovr));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    vec_t vecs[6];
    exp_t hold_e;
    int   n;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, e: '{s: 8'h10, cout: 1'b0, ovr: 1'b0}};
    vecs[1] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, e: '{s: 8'h00, cout: 1'b1, ovr: 1'b0}};
    vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, e: '{s: 8'h80, cout: 1'b0, ovr: 1'b1}};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, e: '{s: 8'h00, cout: 1'b1, ovr: 1'b1}};
    vecs[4] = '{a: 8'h3C, b: 8'h5A, cin: 1'b1, e: '{s: 8'h97, cout: 1'b0, ovr: 1'b1}};
    vecs[5] = '{a: 8'hC8, b: 8'h9B, cin: 1'b0, e: '{s: 8'h63, cout: 1'b1, ovr: 1'b1}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'hA5; b = 8'h5A; cin = 1'b1;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout_ovr", {30'd0, cout, ovr}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 6; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e, i[0]);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      do_txn($sformatf("rnd%0d", i), ra, rb, rc, model(ra, rb, rc), 1'b0);
    end

    // Backpressure: result must hold and new operands must be refused.
    a = 8'h55; b = 8'hAA; cin = 1'b1; in_valid = 1'b1;
    hold_e = '{s: 8'h00, cout: 1'b1, ovr: 1'b0};
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("hold_latency", 32'(n), 32'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); a = 8'h01; b = 8'h02; cin = 1'b0;
      chk("hold_s", 32'(s), 32'(hold_e.s));
      chk("hold_cout_ovr", {30'd0, cout, ovr}, {30'd0, hold_e.cout, hold_e.ovr});
      chk("hold_flags", {30'd0, in_ready, out_valid}, 32'b01);
      tick();
    end
    chk("hold_s_end", 32'(s), 32'(hold_e.s));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release", {30'd0, in_ready, out_valid}, 32'b10);

    // Reset asserted while slice 2 is being added aborts the transaction.
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_flags", {30'd0, in_ready, out_valid}, 32'b10);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_cout_ovr", {30'd0, cout, ovr}, 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("abort_no_valid", 32'(n), 32'd0);
    do_txn("post_abort", 8'h01, 8'h01, 1'b0, '{s: 8'h02, cout: 1'b0, ovr: 1'b0}, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_cla_adder.md
SERIAL_CLA_ADDER -- requirements
Module: serial_cla_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Parameter derived: SLICES = WIDTH/2, number of 2-bit slices per add; not overridable.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operand set valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  operand A, two's complement or unsigned.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in of the full add.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 s  output  WIDTH  sum (a + b + cin) mod 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 ovr  output  1  signed overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; in_valid=1 at a rising edge SHALL capture a, b, cin into internal registers, clear slice counter, go to RUN.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-019 RUN: each cycle one 2-bit slice (bits 2k+1:2k, k = slice counter, LSB slice first) SHALL be added with the registered carry through one 2-bit CLA; slice sum written to s bits 2k+1:2k, slice carry-out written to carry register.
REQ-020 Slice counter SHALL increment each RUN cycle; after slice SLICES-1 it SHALL wrap to 0 and FSM SHALL go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly SLICES clock edges after the acceptance edge (4 for WIDTH=8).
REQ-022 DONE: out_valid=1; s, cout, ovr SHALL stay stable until out_valid && out_ready at a rising edge, then FSM SHALL go to IDLE (one bubble cycle between transactions).
REQ-023 cout SHALL equal carry out of final slice.
REQ-024 ovr SHALL be 1 iff a[WIDTH-1] == b[WIDTH-1] and s[WIDTH-1] != a[WIDTH-1], using captured operands.
REQ-025 Changes on a, b, cin after acceptance SHALL not affect the result.
REQ-026 out_ready while not DONE SHALL have no effect.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE from any state, including mid-RUN, aborting the transaction.
REQ-028 Reset values: in_ready=1 after reset, out_valid=0, s=0, cout=0, ovr=0, carry register=0, slice counter=0.
REQ-029 A transaction aborted by reset SHALL never produce out_valid.

Structure
REQ-030 Shared package SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-031 Exactly one instance of the existing 2-bit CLA sub-module cla_adder_2bits SHALL perform all slice additions; no other adder logic permitted.
REQ-032 Operand selection (slice mux), carry register, result register, and FSM SHALL live in serial_cla_adder.

Verification
REQ-033 WIDTH=8, a=8'h0F b=8'h01 cin=0 -> s=8'h10 cout=0 ovr=0, out_valid exactly 4 edges after acceptance.
REQ-034 a=8'hFF b=8'h00 cin=1 -> s=8'h00 cout=1 ovr=0.
REQ-035 a=8'h7F b=8'h01 cin=0 -> s=8'h80 cout=0 ovr=1; a=8'h80 b=8'h80 cin=0 -> s=8'h00 cout=1 ovr=1.
REQ-036 Result of a=8'h55 b=8'hAA cin=1 (s=8'h00 cout=1) with out_ready held 0 for 3 cycles -> s/cout/ovr stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-037 Change a/b every cycle during RUN -> result matches operands captured at acceptance.
REQ-038 rst_n=0 for one edge during slice 2 -> next cycle IDLE, in_ready=1, out_valid=0 and stays 0; following transaction a=8'h01 b=8'h01 cin=0 -> s=8'h02 cout=0 ovr=0.
